program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Boot-time loader sitting upstream of the single-cycle CPU's unified memory.
//  Accepts a big-endian byte stream (16-bit word count, then 4 bytes per word),
//  packs bytes into 32-bit instructions and writes them to consecutive word
//  addresses. Holds the CPU stalled (cpu_run=0) until the image is complete.
// PARAMETERS
//  ADDR_W     10  width of memory byte address (matches memory DataAddr/InstrAddr)
//  BASE_ADDR  0   byte address of first loaded word; must be multiple of 4
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  in_valid     in   1       byte on in_data is valid
//  in_data      in   8       stream byte
//  in_ready     out  1       loader can accept a byte this cycle
//  reload       in   1       restart load from DONE/ERROR; ignored elsewhere
//  mem_we       out  1       one-cycle write strobe to memory
//  mem_addr     out  ADDR_W  byte address of write (low 2 bits always 0)
//  mem_data     out  32      word to write
//  cpu_run      out  1       image loaded; CPU may execute
//  busy         out  1       load in progress (LEN_HI..WRITE)
//  error        out  1       requested length exceeds memory; sticky until reload/reset
//  words_loaded out  16      words written in current load
// BEHAVIOUR
//  - Byte accepted on rising edge where in_valid & in_ready. in_data ignored otherwise.
//  - All outputs registered. Reset values: in_ready=0 for reset cycle then 1 in LEN_HI,
//    mem_we=0, mem_addr=BASE_ADDR, mem_data=0, cpu_run=0, busy=1, error=0, words_loaded=0.
//  - States: LEN_HI -> LEN_LO -> DATA <-> WRITE -> DONE; LEN_LO -> ERROR; LEN_LO -> DONE.
//    LEN_HI: accept byte -> count[15:8]; go LEN_LO.
//    LEN_LO: accept byte -> count[7:0]. If count==0 go DONE. If
//      count > 2^(ADDR_W-2) - BASE_ADDR/4 go ERROR. Else go DATA, byte index=0.
//    DATA: accept byte into word, big-endian: index 0 -> [31:24] .. 3 -> [7:0].
//      On 4th byte go WRITE.
//    WRITE: in_ready=0, mem_we=1 exactly one cycle with assembled word and current
//      address. Next cycle: mem_addr += 4, words_loaded += 1; if words_loaded==count
//      go DONE else DATA.
//    DONE: cpu_run=1, busy=0, in_ready=0. reload=1 -> LEN_HI, cpu_run=0 next cycle.
//    ERROR: error=1, cpu_run=0, busy=0, in_ready=0. reload=1 -> LEN_HI, error clears.
//  - Latency: 4th data byte accepted at edge k -> mem_we high in cycle k+1 ->
//    in_ready high again in cycle k+2. Max throughput 4 bytes per 5 cycles.
//  - in_ready is 1 in LEN_HI, LEN_LO, DATA only; stalls on in_valid=0 indefinitely,
//    partial word retained.
//  - Address never wraps: length check guarantees last write at
//    BASE_ADDR + 4*(count-1) <= 2^ADDR_W - 4. Count exactly filling memory is legal.
//  - reload entering LEN_HI resets mem_addr=BASE_ADDR, words_loaded=0, byte index=0;
//    reload and in_valid together in DONE: reload wins, byte not accepted.
//  - rst_n low mid-load: immediate return to reset values; words already written stay
//    in memory (no clear). mem_we drops asynchronously.
// TESTING
//  - Stream 00 02 | 20 08 00 05 | 08 00 00 00 -> mem_we at addr 0 data 0x20080005,
//    addr 4 data 0x08000000; cpu_run=1 after 2nd write; words_loaded=2.
//  - Stream 00 00 -> DONE directly, no mem_we pulse, cpu_run=1, words_loaded=0.
//  - ADDR_W=10, BASE_ADDR=0, count 0x0101 -> ERROR, error=1, no writes; count
//    0x0100 -> 256 writes, last at addr 0x3FC, cpu_run=1.
//  - Random in_valid gaps (50% duty) on 3-word image -> identical memory contents and
//    no byte dropped/duplicated; in_ready=0 during each WRITE cycle.
//  - Drop rst_n after 2 bytes of word 1 -> all outputs at reset values; restreamed
//    image 00 01 DE AD BE EF -> addr 0 data 0xDEADBEEF.
//  - In DONE assert reload with in_valid=1, in_data=0xFF -> cpu_run=0 next cycle,
//    byte ignored, next accepted byte taken as LEN_HI.

Source files
------------

// File: rtl/program_loader.sv
// Boot loader: packs a big-endian byte stream (16-bit word count, then 4 bytes per word)
// into 32-bit words and writes them to consecutive memory words, holding the CPU until done.
module program_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              cpu_run,
  output logic              busy,
  output logic              error,
  output logic [15:0]       words_loaded
);

  // Number of words that fit between BASE_ADDR and the top of memory.
  localparam logic [32:0] MaxWords = (33'd1 << (ADDR_W - 2)) - 33'(BASE_ADDR / 4);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    StLenHi,
    StLenLo,
    StData,
    StWrite,
    StDone,
    StError
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [15:0]       wl_q, wl_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic              cpu_run_q, cpu_run_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;

  logic        accept;
  logic [15:0] new_count;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    word_d    = word_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wl_d      = wl_q;
    accept    = in_valid & in_ready_q;
    new_count = {count_q[15:8], in_data};

    unique case (state_q)
      StLenHi: begin
        if (accept) begin
          count_d[15:8] = in_data;
          state_d       = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          count_d = new_count;
          idx_d   = 2'd0;
          if (new_count == 16'd0) begin
            state_d = StDone;
          end else if (33'(new_count) > MaxWords) begin
            state_d = StError;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          // Shifting in from the bottom places byte 0 in [31:24] after four bytes.
          word_d = {word_q[23:0], in_data};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            data_d  = {word_q[23:0], in_data};
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        addr_d  = addr_q + ADDR_W'(4);
        wl_d    = wl_q + 16'd1;
        state_d = (wl_q + 16'd1 == count_q) ? StDone : StData;
      end
      StDone, StError: begin
        if (reload) begin
          state_d = StLenHi;
          addr_d  = BaseAddr;
          wl_d    = 16'd0;
          idx_d   = 2'd0;
        end
      end
      default: state_d = StLenHi;
    endcase

    in_ready_d = (state_d == StLenHi) || (state_d == StLenLo) || (state_d == StData);
    mem_we_d   = (state_d == StWrite);
    busy_d     = (state_d != StDone) && (state_d != StError);
    cpu_run_d  = (state_d == StDone);
    error_d    = (state_d == StError);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLenHi;
      count_q    <= 16'd0;
      idx_q      <= 2'd0;
      word_q     <= 32'd0;
      addr_q     <= BaseAddr;
      data_q     <= 32'd0;
      wl_q       <= 16'd0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      cpu_run_q  <= 1'b0;
      busy_q     <= 1'b1;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wl_q       <= wl_d;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      cpu_run_q  <= cpu_run_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign cpu_run      = cpu_run_q;
  assign busy         = busy_q;
  assign error        = error_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: the driver queues expected writes, a negedge
// monitor pops and compares each mem_we pulse.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        reload = 1'b0;
  logic        in_ready, mem_we, cpu_run, busy, error;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic [15:0] words_loaded;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  gaps = 1'b0;

  program_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .reload       (reload),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .cpu_run      (cpu_run),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr %h data %h required none", mem_addr,
                 mem_data);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("wr_addr", 32'(mem_addr), e.addr);
        chk("wr_data", mem_data, e.data);
      end
      chk("in_ready_in_write", 32'(in_ready), 32'd0);
    end
  end

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (gaps) begin
      int idle = int'($urandom_range(0, 2));
      for (int i = 0; i < idle; i++) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] addr);
    wr_t e;
    e.addr = addr;
    e.data = w;
    sb_q.push_back(e);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (!cpu_run && !error && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_run && !error) chk(name, 32'd0, 32'd1);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_cpu_run", 32'(cpu_run), 32'd0);
    chk("reload_error", 32'(error), 32'd0);
    chk("reload_words", 32'(words_loaded), 32'd0);
    chk("reload_addr", 32'(mem_addr), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_data"}, mem_data, 32'd0);
    chk({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Two-word image.
    send_len(16'h0002);
    send_word(32'h20080005, 32'h000);
    send_word(32'h08000000, 32'h004);
    wait_end("t1_done_timeout");
    chk("t1_cpu_run", 32'(cpu_run), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_words", 32'(words_loaded), 32'd2);
    chk("t1_in_ready", 32'(in_ready), 32'd0);

    // Zero-length image.
    do_reload();
    send_len(16'h0000);
    wait_end("t2_done_timeout");
    chk("t2_cpu_run", 32'(cpu_run), 32'd1);
    chk("t2_words", 32'(words_loaded), 32'd0);

    // One word too many for 1 KiB.
    do_reload();
    send_len(16'h0101);
    wait_end("t3_err_timeout");
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_cpu_run", 32'(cpu_run), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("t3_error_sticky", 32'(error), 32'd1);

    // Image exactly filling memory.
    do_reload();
    send_len(16'h0100);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send_word({b, 8'hC3, ~b, 8'h5A}, 32'(4 * i));
    end
    wait_end("t4_done_timeout");
    chk("t4_cpu_run", 32'(cpu_run), 32'd1);
    chk("t4_words", 32'(words_loaded), 32'd256);
    chk("t4_sb_empty", 32'(sb_q.size()), 32'd0);

    // Three-word image with random valid gaps.
    do_reload();
    gaps = 1'b1;
    send_len(16'h0003);
    send_word(32'hCAFEF00D, 32'h000);
    send_word(32'h01234567, 32'h004);
    send_word(32'h89ABCDEF, 32'h008);
    gaps = 1'b0;
    wait_end("t5_done_timeout");
    chk("t5_words", 32'(words_loaded), 32'd3);
    chk("t5_cpu_run", 32'(cpu_run), 32'd1);

    // reload with a byte presented in DONE: byte must be ignored.
    reload   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge clk);
    reload   = 1'b0;
    in_valid = 1'b0;
    chk("t6_cpu_run", 32'(cpu_run), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    send_len(16'h0001);
    send_word(32'h12345678, 32'h000);
    wait_end("t6_done_timeout");
    chk("t6_error", 32'(error), 32'd0);
    chk("t6_words", 32'(words_loaded), 32'd1);

    // Reset in the middle of word 1.
    do_reload();
    send_len(16'h0001);
    send_byte(8'hDE);
    send_byte(8'hAD);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_len(16'h0001);
    send_word(32'hDEADBEEF, 32'h000);
    wait_end("t7_done_timeout");
    chk("t7_cpu_run", 32'(cpu_run), 32'd1);
    chk("t7_words", 32'(words_loaded), 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
